fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the instruction-memory port on behalf of the RV32C fetch buffer.
- Issues word-aligned reads at the fetch buffer's imem_pc and delivers returned words as single-cycle inst_arrived pulses.
- Holds returned data while decode is stalled.
- Converts pipeline redirects (branch, jump, exception) into a one-cycle fetch-buffer reset pulse, squashing any in-flight read first.
- Sits between fetch_buffer and the instruction-side generic bus.

Parameters:
- ADDR_W, 32, width of PCs and bus address.
- DATA_W, 32, bus read-data width; fixed at 32 for RV32.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- fb_imem_pc  input  ADDR_W  word-aligned fetch address from fetch buffer
- inst_arrived  output  1  one-cycle pulse: inst is valid and is consumed this cycle
- inst  output  DATA_W  instruction word to fetch buffer
- fb_reset_en  output  1  one-cycle pulse: fetch buffer reloads from fb_reset_pc
- fb_reset_pc  output  ADDR_W  redirect target (may be halfword-aligned)
- redirect_en  input  1  pipeline redirect request, single-cycle pulse
- redirect_pc  input  ADDR_W  redirect target
- stall  input  1  decode cannot accept an instruction this cycle
- imem_ren  output  1  bus read request
- imem_addr  output  ADDR_W  bus address, {fb_imem_pc[ADDR_W-1:2],2'b00}
- imem_busy  input  1  bus busy; read completes in a cycle with imem_ren=1 and imem_busy=0
- imem_rdata  input  DATA_W  bus read data, valid on the completion cycle
- squash_cnt  output  16  count of discarded bus completions (perf)

Behaviour:
- Clock and reset: one clock, clk; reset n_rst asynchronous, active-low.
- Reset state is BOOT. All outputs are 0 and all registers are cleared, including pend_pc, hold_q and squash_cnt.
- BOOT: all outputs 0; next state FETCH unconditionally, unless redirect_en, which goes to REDIR.
- FETCH:
  - imem_ren=1; imem_addr tracks fb_imem_pc.
  - Fetch buffer keeps imem_pc stable while busy, so the address is stable for the whole transaction.
  - On completion with no redirect and !stall: inst=imem_rdata, inst_arrived=1 combinationally, stay FETCH. Zero-wait-state memory gives 1 word/cycle.
  - On completion with stall: capture imem_rdata into hold_q, next state HOLD, inst_arrived=0.
  - Redirect while imem_busy=1: latch redirect_pc into pend_pc, next state DRAIN.
  - Redirect on the completion cycle: data discarded, inst_arrived=0, squash_cnt+1, latch pend_pc, next state REDIR.
- HOLD:
  - imem_ren=0; inst=hold_q.
  - inst_arrived = !stall; on delivery, next state FETCH.
  - Redirect: drop hold_q without counting, latch pend_pc, next state REDIR. Redirect wins over delivery in the same cycle.
- DRAIN:
  - imem_ren=1 and imem_addr held at the in-flight address, registered on DRAIN entry; inst_arrived=0.
  - A further redirect overwrites pend_pc (latest wins).
  - On completion: squash_cnt+1, next state REDIR.
- REDIR:
  - imem_ren=0; fb_reset_en=1; fb_reset_pc=pend_pc; next state FETCH.
  - The fetch buffer loads aligned imem_pc at this edge, so the first request at the new target issues the next cycle.
  - A redirect arriving in REDIR updates pend_pc and stays in REDIR, pulsing fb_reset_en again with the new target.
- Invariants:
  - inst_arrived and fb_reset_en are never high together.
  - inst_arrived never asserts while stall=1.
  - imem_ren never deasserts mid-transaction (busy=1).
  - squash_cnt saturates at 16'hFFFF.
- Reset asserted mid-transaction: return to BOOT. The outstanding bus read is abandoned; the bus is reset by the same n_rst.
- Redirect latency: redirect in cycle N with an idle bus gives fb_reset_en in N+1 and imem_ren at the new target in N+2.

Decomposition:
- Package fetch_ctrl_pkg: state enum fetch_ctrl_state_t {BOOT, FETCH, HOLD, DRAIN, REDIR}, and constant SQUASH_CNT_MAX.
- No sub-module. The hold register, pend_pc register and saturating counter stay inline.

Test Plan:
- Reset release, imem_busy=0, rdata=32'h00A00093 → BOOT 1 cycle, then imem_ren=1 at addr 32'h200 and inst_arrived pulses each cycle; fb_imem_pc advances 0x200, 0x204, 0x208.
- imem_busy=1 for 3 cycles, then 0 with stall=1 for 2 cycles → data in hold_q, imem_ren=0; inst_arrived pulses the cycle stall drops with the same word.
- redirect_en with redirect_pc=32'h00000406 while busy=1 → DRAIN holds addr until busy=0; squash_cnt=1; fb_reset_en pulse with fb_reset_pc=32'h406; next imem_addr=32'h404.
- Redirect on the completion cycle → inst_arrived stays 0, squash_cnt increments, fb_reset_en on the next cycle.
- Two redirects (0x300 in DRAIN, then 0x500 in REDIR) → two fb_reset_en pulses, the last with 32'h500; fetch resumes at 0x500.
- n_rst asserted during DRAIN → all outputs 0 immediately, state BOOT, squash_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    HOLD,
    DRAIN,
    REDIR
  } fetch_ctrl_state_t;

  localparam logic [15:0] SQUASH_CNT_MAX = 16'hFFFF;

  // Saturating increment for the squash performance counter.
  function automatic logic [15:0] squash_inc(input logic [15:0] cnt);
    return (cnt == SQUASH_CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-memory port sequencer for the RV32C fetch buffer: issues reads, holds data
// across decode stalls and turns pipeline redirects into fetch-buffer reset pulses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] fb_imem_pc,
  output logic              inst_arrived,
  output logic [DATA_W-1:0] inst,
  output logic              fb_reset_en,
  output logic [ADDR_W-1:0] fb_reset_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              imem_ren,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_busy,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [15:0]       squash_cnt
);

  fetch_ctrl_state_t state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [15:0]       squash_cnt_q, squash_cnt_d;
  logic [ADDR_W-1:0] aligned_pc;

  assign aligned_pc = {fb_imem_pc[ADDR_W-1:2], 2'b00};
  assign squash_cnt = squash_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= BOOT;
      pend_pc_q    <= '0;
      drain_addr_q <= '0;
      hold_q       <= '0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_pc_q    <= pend_pc_d;
      drain_addr_q <= drain_addr_d;
      hold_q       <= hold_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_pc_d    = pend_pc_q;
    drain_addr_d = drain_addr_q;
    hold_d       = hold_q;
    squash_cnt_d = squash_cnt_q;
    inst_arrived = 1'b0;
    inst         = '0;
    fb_reset_en  = 1'b0;
    fb_reset_pc  = '0;
    imem_ren     = 1'b0;
    imem_addr    = '0;

    unique case (state_q)
      BOOT: begin
        if (redirect_en) begin
          pend_pc_d = redirect_pc;
          state_d   = REDIR;
        end else begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        imem_ren  = 1'b1;
        imem_addr = aligned_pc;
        if (redirect_en) begin
          pend_pc_d = redirect_pc;
          if (imem_busy) begin
            // Bus cannot be cancelled; finish the read at the same address, then discard it.
            drain_addr_d = aligned_pc;
            state_d      = DRAIN;
          end else begin
            squash_cnt_d = squash_inc(squash_cnt_q);
            state_d      = REDIR;
          end
        end else if (!imem_busy) begin
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            inst_arrived = 1'b1;
            inst         = imem_rdata;
          end
        end
      end

      HOLD: begin
        inst = hold_q;
        if (redirect_en) begin
          pend_pc_d = redirect_pc;
          state_d   = REDIR;
        end else if (!stall) begin
          inst_arrived = 1'b1;
          state_d      = FETCH;
        end
      end

      DRAIN: begin
        imem_ren  = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect_en) begin
          pend_pc_d = redirect_pc;
        end
        if (!imem_busy) begin
          squash_cnt_d = squash_inc(squash_cnt_q);
          state_d      = REDIR;
        end
      end

      REDIR: begin
        fb_reset_en = 1'b1;
        fb_reset_pc = pend_pc_q;
        if (redirect_en) begin
          pend_pc_d = redirect_pc;
        end else begin
          state_d = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with hand-written reset/redirect corner sequences.
module tb_fetch_ctrl;

  logic        clk;
  logic        n_rst;
  logic [31:0] fb_imem_pc;
  logic        inst_arrived;
  logic [31:0] inst;
  logic        fb_reset_en;
  logic [31:0] fb_reset_pc;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic [15:0] squash_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .fb_imem_pc  (fb_imem_pc),
    .inst_arrived(inst_arrived),
    .inst        (inst),
    .fb_reset_en (fb_reset_en),
    .fb_reset_pc (fb_reset_pc),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_busy   (imem_busy),
    .imem_rdata  (imem_rdata),
    .squash_cnt  (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        e_arr;
    logic [31:0] e_inst;
    logic        e_fre;
    logic [31:0] e_frpc;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [15:0] e_sq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic stl,
                              input logic busy, input logic [31:0] rdata, input logic [31:0] pc,
                              input logic e_arr, input logic [31:0] e_inst, input logic e_fre,
                              input logic [31:0] e_frpc, input logic e_ren,
                              input logic [31:0] e_addr, input logic [15:0] e_sq);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.stl = stl; v.busy = busy; v.rdata = rdata; v.pc = pc;
    v.e_arr = e_arr; v.e_inst = e_inst; v.e_fre = e_fre; v.e_frpc = e_frpc;
    v.e_ren = e_ren; v.e_addr = e_addr; v.e_sq = e_sq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic arr, input logic [31:0] i,
                         input logic fre, input logic [31:0] frpc, input logic ren,
                         input logic [31:0] addr, input logic [15:0] sq);
    chk({tag, " inst_arrived"}, {31'd0, inst_arrived}, {31'd0, arr});
    chk({tag, " inst"}, inst, i);
    chk({tag, " fb_reset_en"}, {31'd0, fb_reset_en}, {31'd0, fre});
    chk({tag, " fb_reset_pc"}, fb_reset_pc, frpc);
    chk({tag, " imem_ren"}, {31'd0, imem_ren}, {31'd0, ren});
    chk({tag, " imem_addr"}, imem_addr, addr);
    chk({tag, " squash_cnt"}, {16'd0, squash_cnt}, {16'd0, sq});
    chk({tag, " arrived_with_reset"}, {31'd0, inst_arrived & fb_reset_en}, 32'd0);
    chk({tag, " arrived_with_stall"}, {31'd0, inst_arrived & stall}, 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; fb_imem_pc = '0; redirect_en = 1'b0; redirect_pc = '0;
    stall = 1'b0; imem_busy = 1'b0; imem_rdata = 32'h00A00093;

    //          redir rpc          stl busy rdata         pc            arr inst          fre frpc         ren addr          sq
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h00A00093, 32'h200, 0, 32'h0,        0, 32'h0,   0, 32'h0,   16'd0)); // 0 BOOT
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h00A00093, 32'h200, 1, 32'h00A00093, 0, 32'h0,   1, 32'h200, 16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h00A00093, 32'h204, 1, 32'h00A00093, 0, 32'h0,   1, 32'h204, 16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h00A00093, 32'h208, 1, 32'h00A00093, 0, 32'h0,   1, 32'h208, 16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 1, 32'hBAD0BAD0, 32'h20C, 0, 32'h0,        0, 32'h0,   1, 32'h20C, 16'd0)); // 4 busy
    vecs.push_back(mk(0, 32'h0,   0, 1, 32'hBAD0BAD0, 32'h20C, 0, 32'h0,        0, 32'h0,   1, 32'h20C, 16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 1, 32'hBAD0BAD0, 32'h20C, 0, 32'h0,        0, 32'h0,   1, 32'h20C, 16'd0));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h11111113, 32'h20C, 0, 32'h0,        0, 32'h0,   1, 32'h20C, 16'd0)); // 7 -> HOLD
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'hDEADBEEF, 32'h20C, 0, 32'h11111113, 0, 32'h0,   0, 32'h0,   16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'hDEADBEEF, 32'h20C, 1, 32'h11111113, 0, 32'h0,   0, 32'h0,   16'd0));
    vecs.push_back(mk(1, 32'h406, 0, 1, 32'hBAD0BAD0, 32'h210, 0, 32'h0,        0, 32'h0,   1, 32'h210, 16'd0)); // 10 -> DRAIN
    vecs.push_back(mk(0, 32'h0,   0, 1, 32'hBAD0BAD0, 32'hF00, 0, 32'h0,        0, 32'h0,   1, 32'h210, 16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h77777773, 32'hF00, 0, 32'h0,        0, 32'h0,   1, 32'h210, 16'd0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h77777773, 32'hF00, 0, 32'h0,        1, 32'h406, 0, 32'h0,   16'd1)); // 13 REDIR
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h22222223, 32'h404, 1, 32'h22222223, 0, 32'h0,   1, 32'h404, 16'd1));
    vecs.push_back(mk(1, 32'h600, 0, 0, 32'h33333333, 32'h408, 0, 32'h0,        0, 32'h0,   1, 32'h408, 16'd1)); // 15
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h33333333, 32'h408, 0, 32'h0,        1, 32'h600, 0, 32'h0,   16'd2));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h12345673, 32'h600, 1, 32'h12345673, 0, 32'h0,   1, 32'h600, 16'd2));
    vecs.push_back(mk(1, 32'h100, 0, 1, 32'hBAD0BAD0, 32'h604, 0, 32'h0,        0, 32'h0,   1, 32'h604, 16'd2)); // 18
    vecs.push_back(mk(1, 32'h300, 0, 1, 32'hBAD0BAD0, 32'h604, 0, 32'h0,        0, 32'h0,   1, 32'h604, 16'd2));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'hBAD0BAD0, 32'h604, 0, 32'h0,        0, 32'h0,   1, 32'h604, 16'd2));
    vecs.push_back(mk(1, 32'h500, 0, 0, 32'hBAD0BAD0, 32'h604, 0, 32'h0,        1, 32'h300, 0, 32'h0,   16'd3));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'hBAD0BAD0, 32'h604, 0, 32'h0,        1, 32'h500, 0, 32'h0,   16'd3));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h44444443, 32'h500, 1, 32'h44444443, 0, 32'h0,   1, 32'h500, 16'd3));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h55555553, 32'h504, 0, 32'h0,        0, 32'h0,   1, 32'h504, 16'd3)); // 24
    vecs.push_back(mk(1, 32'h802, 0, 0, 32'hBAD0BAD0, 32'h504, 0, 32'h55555553, 0, 32'h0,   0, 32'h0,   16'd3));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'hBAD0BAD0, 32'h504, 0, 32'h0,        1, 32'h802, 0, 32'h0,   16'd3));
    vecs.push_back(mk(0, 32'h0,   0, 1, 32'hBAD0BAD0, 32'h800, 0, 32'h0,        0, 32'h0,   1, 32'h800, 16'd3));

    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    foreach (vecs[i]) begin
      redirect_en = vecs[i].redir; redirect_pc = vecs[i].rpc; stall = vecs[i].stl;
      imem_busy = vecs[i].busy; imem_rdata = vecs[i].rdata; fb_imem_pc = vecs[i].pc;
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].e_arr, vecs[i].e_inst, vecs[i].e_fre,
              vecs[i].e_frpc, vecs[i].e_ren, vecs[i].e_addr, vecs[i].e_sq);
      @(posedge clk);
      #1;
    end

    // Reset asserted while draining an in-flight read.
    redirect_en = 1'b1; redirect_pc = 32'h900; imem_busy = 1'b1; fb_imem_pc = 32'h800;
    @(posedge clk);
    #1 redirect_en = 1'b0;
    @(negedge clk);
    chk_all("drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h800, 16'd3);
    n_rst = 1'b0;
    #1;
    chk_all("rst_in_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    @(posedge clk);
    #1 n_rst = 1'b1; imem_busy = 1'b0; imem_rdata = 32'h66666663;
    @(negedge clk);
    chk_all("boot_again", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all("fetch_after_rst", 1'b1, 32'h66666663, 1'b0, 32'h0, 1'b1, 32'h800, 16'd0);

    // Redirect arriving in BOOT goes straight to REDIR.
    n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'hA02;
    @(negedge clk);
    chk_all("boot_redir", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    @(posedge clk);
    #1 redirect_en = 1'b0;
    @(negedge clk);
    chk_all("redir_from_boot", 1'b0, 32'h0, 1'b1, 32'hA02, 1'b0, 32'h0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
